operand_b_sel_pipe: RTL and testbench
=====================================

Name: operand_b_sel_pipe

Overview:
- Parametrised successor to the ALU operand-B selector.
- Selects one of four sources: B register, constant zero, extended immediate, or loopback of the last issued operand.
- Registers the result in a single-stage valid/ready pipeline slot between decode and the ALU.
- Fully defines the select code that the previous generation left undriven, and keeps a saturating count of issued operands for debug.

Parameters:
- WIDTH, 8, datapath width of B, loopback and out_data.
- IMM_WIDTH, 8, width of the immediate input; must satisfy 1 <= IMM_WIDTH <= WIDTH.
- CNT_WIDTH, 8, width of the issued-operand counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream offers a selection this cycle.
- in_ready  output  1  slot can accept this cycle.
- s  input  2  source select: 00 B, 01 zero, 10 immediate, 11 loopback.
- sext  input  1  1 = sign-extend Im, 0 = zero-extend Im.
- B  input  WIDTH  register-file operand.
- Im  input  IMM_WIDTH  instruction immediate.
- out_valid  output  1  out_data holds an operand not yet consumed.
- out_ready  input  1  ALU consumes out_data this cycle.
- out_data  output  WIDTH  registered selected operand.
- issued  output  CNT_WIDTH  number of accepted selections, saturating.

Behaviour:
- Reset (rst high at a clock edge): out_valid=0, out_data=0, issued=0. Reset overrides any simultaneous handshake.
- While rst is high, in_ready is still computed combinationally, but no transfer is recorded.
- Reset mid-operation discards any pending operand.
- in_ready = !out_valid || out_ready. This is purely combinational, with no dependency on in_valid.
- Accept: fires when in_valid && in_ready at a clock edge.
  - out_data <= sel_value.
  - out_valid <= 1.
  - issued <= issued+1, unless issued is already all ones; it then saturates and holds.
- No accept, out_ready=1: out_valid <= 0. out_data holds its value; it is not cleared.
- No accept, out_ready=0: out_valid and out_data hold. Stall: the operand is held stable until consumed.
- Simultaneous consume and accept (out_valid=1, out_ready=1, in_valid=1): the new operand replaces the old in one cycle, with no bubble and out_valid staying 1. Throughput is one operand per cycle.
- Latency: the operand appears on out_data exactly 1 cycle after the accepting edge.
- sel_value, computed combinationally from the inputs sampled at the accepting edge:
  - s=00: B.
  - s=01: all zeros.
  - s=10: Im extended to WIDTH. If sext=1, copy Im[IMM_WIDTH-1] into the upper bits; if sext=0, fill the upper bits with zeros. When IMM_WIDTH == WIDTH, Im is passed unchanged.
  - s=11: current out_data register, i.e. the last accepted operand. This applies whether or not it has been consumed, and whether out_valid is 0 or 1. After reset it yields 0.
- sext is ignored for every s other than 10.
- No select code is undefined. No latches are inferred; the output is a flip-flop only.
- Inputs s, sext, B and Im are don't-care when in_valid=0. No state changes other than the out_valid clear described above.

Test Plan:
- Reset then idle: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0x00, issued=0 after release; the first accept happens only on the edge after rst falls.
- Source sweep (WIDTH=8, IMM_WIDTH=4, out_ready=1): issue back-to-back s=00 B=0x5A; s=01; s=10 Im=0xA sext=1; s=10 Im=0xA sext=0; s=11.
  - Required out_data sequence on consecutive cycles: 0x5A, 0x00, 0xFA, 0x0A, 0x0A.
  - out_valid stays 1 throughout; issued=5.
- Stall/hold: accept B=0x33, then hold out_ready=0 for 3 cycles with in_valid=1, B=0x44 -> in_ready=0 and out_data=0x33 for all 3 cycles. Raise out_ready -> 0x44 is accepted on that same edge and appears the next cycle, with no bubble.
- Bubble: accept 0x11, then in_valid=0 with out_ready=1 -> out_valid drops to 0 and out_data stays 0x11. Then issue s=11 -> out_data=0x11, out_valid=1.
- Counter saturation (CNT_WIDTH=3): perform 9 accepts -> issued reads 1..7, then stays at 7.
- Reset mid-stall: out_valid=1, out_ready=0, then rst high 1 cycle -> out_valid=0, out_data=0, issued=0. A following s=11 accept yields 0x00.

Source files
------------

// File: rtl/operand_b_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : operand_b_sel_pipe
// Purpose  : ALU operand-B selector (B / zero / extended immediate / loopback)
//            registered in a single valid/ready slot, with a saturating
//            count of issued operands.
// Revision : 1.0 - initial release
// ============================================================================
module operand_b_sel_pipe #(
  parameter int WIDTH     = 8,
  parameter int IMM_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           s,
  input  logic                 sext,
  input  logic [WIDTH-1:0]     B,
  input  logic [IMM_WIDTH-1:0] Im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] issued
);

  localparam logic [1:0] c_sel_b    = 2'b00;
  localparam logic [1:0] c_sel_zero = 2'b01;
  localparam logic [1:0] c_sel_imm  = 2'b10;

  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_issued;

  logic [WIDTH-1:0]     w_imm_ext;
  logic [WIDTH-1:0]     w_sel;
  logic                 w_accept;

  generate
    if (IMM_WIDTH == WIDTH) begin : g_imm_full
      assign w_imm_ext = Im;
    end else begin : g_imm_ext
      assign w_imm_ext = {{(WIDTH-IMM_WIDTH){sext & Im[IMM_WIDTH-1]}}, Im};
    end
  endgenerate

  // Loopback (s=11) returns the last accepted operand, consumed or not.
  always_comb begin
    w_sel = r_data;
    case (s)
      c_sel_b:    w_sel = B;
      c_sel_zero: w_sel = '0;
      c_sel_imm:  w_sel = w_imm_ext;
      default:    w_sel = r_data;
    endcase
  end

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_issued <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_sel;
      if (r_issued != {CNT_WIDTH{1'b1}}) begin
        r_issued <= r_issued + CNT_WIDTH'(1);
      end
    end else if (out_ready) begin
      // Consumed with nothing new: drop valid, keep data for loopback.
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign issued    = r_issued;

endmodule
`default_nettype wire

// File: tb/tb_operand_b_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_b_sel_pipe
// Purpose  : Directed self-checking bench for operand_b_sel_pipe
//            (WIDTH=8, IMM_WIDTH=4, CNT_WIDTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_b_sel_pipe;

  localparam int WIDTH     = 8;
  localparam int IMM_WIDTH = 4;
  localparam int CNT_WIDTH = 3;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           s;
  logic                 sext;
  logic [WIDTH-1:0]     B;
  logic [IMM_WIDTH-1:0] Im;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] issued;

  int n_checks;
  int n_fail;

  operand_b_sel_pipe #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .sext      (sext),
    .B         (B),
    .Im        (Im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .issued    (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic sx,
                       input logic [WIDTH-1:0] b, input logic [IMM_WIDTH-1:0] im);
    in_valid = v;
    s        = sel;
    sext     = sx;
    B        = b;
    Im       = im;
  endtask

  typedef struct {
    logic [1:0]           sel;
    logic                 sx;
    logic [WIDTH-1:0]     b;
    logic [IMM_WIDTH-1:0] im;
    logic [WIDTH-1:0]     exp;
  } vec_t;

  vec_t sweep[5];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 8'h77, 4'h0);

    // Reset held two cycles with in_valid asserted.
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_issued", 32'(issued), 32'd0);
    rst = 1'b0;
    tick();
    check("first_acc_data", 32'(out_data), 32'h77);
    check("first_acc_valid", 32'(out_valid), 32'd1);
    check("first_acc_issued", 32'(issued), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Source sweep, back-to-back with out_ready=1.
    sweep[0] = '{2'b00, 1'b0, 8'h5A, 4'h0, 8'h5A};
    sweep[1] = '{2'b01, 1'b1, 8'hFF, 4'hF, 8'h00};
    sweep[2] = '{2'b10, 1'b1, 8'hFF, 4'hA, 8'hFA};
    sweep[3] = '{2'b10, 1'b0, 8'hFF, 4'hA, 8'h0A};
    sweep[4] = '{2'b11, 1'b1, 8'hFF, 4'hF, 8'h0A};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sweep[i].sel, sweep[i].sx, sweep[i].b, sweep[i].im);
      tick();
      check($sformatf("sweep%0d_data", i), 32'(out_data), 32'(sweep[i].exp));
      check($sformatf("sweep%0d_valid", i), 32'(out_valid), 32'd1);
    end
    check("sweep_issued", 32'(issued), 32'd5);

    // Stall and hold.
    drive(1'b1, 2'b00, 1'b0, 8'h33, 4'h0);
    tick();
    check("stall_first", 32'(out_data), 32'h33);
    out_ready = 1'b0;
    B = 8'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d_data", i), 32'(out_data), 32'h33);
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(in_ready), 32'd1);
    tick();
    check("unstall_data", 32'(out_data), 32'h44);
    check("unstall_valid", 32'(out_valid), 32'd1);
    check("unstall_issued_sat", 32'(issued), 32'd7);

    // Bubble then loopback.
    drive(1'b1, 2'b00, 1'b0, 8'h11, 4'h0);
    tick();
    check("bubble_acc", 32'(out_data), 32'h11);
    drive(1'b0, 2'b01, 1'b0, 8'hEE, 4'h0);
    tick();
    check("bubble_valid", 32'(out_valid), 32'd0);
    check("bubble_data_hold", 32'(out_data), 32'h11);
    drive(1'b1, 2'b11, 1'b0, 8'hEE, 4'h0);
    tick();
    check("loop_data", 32'(out_data), 32'h11);
    check("loop_valid", 32'(out_valid), 32'd1);

    // Counter saturation from zero.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_start", 32'(issued), 32'd0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'b00, 1'b0, 8'(i + 1), 4'h0);
      tick();
      check($sformatf("sat%0d_issued", i), 32'(issued), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end

    // Reset in the middle of a stall.
    drive(1'b1, 2'b00, 1'b0, 8'h99, 4'h0);
    tick();
    check("mid_acc", 32'(out_data), 32'h99);
    out_ready = 1'b0;
    tick();
    check("mid_stall_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'h00);
    check("mid_rst_issued", 32'(issued), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 1'b0, 8'hAB, 4'h5);
    tick();
    check("post_rst_loop_data", 32'(out_data), 32'h00);
    check("post_rst_loop_valid", 32'(out_valid), 32'd1);
    check("post_rst_issued", 32'(issued), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
